light_normalize: RTL and testbench



---
 rtl/lambert_pkg.sv | 42 ++++
 rtl/light_normalize_isqrt.sv | 92 +++++++++
 rtl/light_normalize.sv | 231 +++++++++++++++++++++++
 tb/tb_light_normalize.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lambert_pkg.sv
// ---------------------------------------------------------------------------
// lambert_pkg
// Shared formats and types for the Lambertian lighting pipeline.
//   IN_FRAC    : fractional bits of the raw light vector (signed Q8.8)
//   UNIT_FRAC  : fractional bits of the unit direction (signed Q1.14)
//   LEN_W      : width of the vector length (unsigned Q8.8)
//   DIV_ITERS  : quotient bits per component; q <= 1.0 needs UNIT_FRAC+1 bits
//   state_t    : normalizer sequencing states
//   vec16_t    : packed 3 x 16-bit vector, shared with the direction stage
//   apply_sign : turns an unsigned quotient into a signed Q1.14 component
// ---------------------------------------------------------------------------
package lambert_pkg;

    localparam int IN_FRAC   = 8;
    localparam int UNIT_FRAC = 14;
    localparam int LEN_W     = 2 * IN_FRAC;
    localparam int DIV_ITERS = UNIT_FRAC + 1;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        SQRT,
        DIV,
        DONE
    } state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vec16_t;

    // Magnitude never exceeds 16384, so the widened value is always positive
    // before the optional negation.
    function automatic logic [15:0] apply_sign(input logic [DIV_ITERS-1:0] mag,
                                               input logic                 neg);
        logic [15:0] wide;
        wide = {1'b0, mag};
        return neg ? -wide : wide;
    endfunction

endpackage

// File: rtl/light_normalize_isqrt.sv
// ---------------------------------------------------------------------------
// isqrt_seq
// Bit-pair restoring integer square root, one root bit per clock.
// The first iteration is performed on the start edge directly from the
// radicand input, so the root is final LEN_W cycles after start and
// done pulses high for exactly one cycle at that point.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, aborts any computation
//   start    : load radicand and begin (single-cycle pulse)
//   radicand : 32-bit unsigned value
//   done     : one-cycle pulse, root is valid from this cycle on
//   root     : floor(sqrt(radicand)), held until the next start
// ---------------------------------------------------------------------------
module isqrt_seq
    import lambert_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*LEN_W-1:0]   radicand,
    output logic                 done,
    output logic [LEN_W-1:0]     root
);

    logic [2*LEN_W-1:0] rad_reg;
    logic [LEN_W+1:0]   rem_reg;
    logic [LEN_W-1:0]   root_reg;
    logic [3:0]         iter_reg;
    logic               active_reg;
    logic               done_reg;

    logic [2*LEN_W-1:0] rad_src;
    logic [LEN_W+1:0]   rem_src;
    logic [LEN_W-1:0]   root_src;
    logic [LEN_W+3:0]   rem_trial;
    logic [LEN_W+3:0]   trial;
    logic               take;
    logic [2*LEN_W-1:0] rad_next;
    logic [LEN_W+1:0]   rem_next;
    logic [LEN_W-1:0]   root_next;

    // On the start edge the step runs on fresh operands instead of the
    // registers, which saves a dedicated load cycle.
    always_comb begin
        rad_src   = start ? radicand : rad_reg;
        rem_src   = start ? '0 : rem_reg;
        root_src  = start ? '0 : root_reg;
        rem_trial = {rem_src, rad_src[2*LEN_W-1 -: 2]};
        trial     = {2'b00, root_src, 2'b01};
        take      = (rem_trial >= trial);
        rad_next  = {rad_src[2*LEN_W-3:0], 2'b00};
        // Remainder stays below 2*root+1, so the upper trial bits are zero.
        rem_next  = (LEN_W+2)'(take ? rem_trial - trial : rem_trial);
        root_next = {root_src[LEN_W-2:0], take};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rad_reg    <= '0;
            rem_reg    <= '0;
            root_reg   <= '0;
            iter_reg   <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else if (start) begin
            rad_reg    <= rad_next;
            rem_reg    <= rem_next;
            root_reg   <= root_next;
            iter_reg   <= 4'd1;
            active_reg <= 1'b1;
            done_reg   <= 1'b0;
        end else if (active_reg) begin
            rad_reg  <= rad_next;
            rem_reg  <= rem_next;
            root_reg <= root_next;
            iter_reg <= iter_reg + 4'd1;
            if (iter_reg == 4'(LEN_W - 1)) begin
                active_reg <= 1'b0;
                done_reg   <= 1'b1;
            end else begin
                done_reg <= 1'b0;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign done = done_reg;
    assign root = root_reg;

endmodule

// File: rtl/light_normalize.sv
// ---------------------------------------------------------------------------
// light_normalize
// Turns a raw signed Q8.8 light vector into a signed Q1.14 unit direction.
// Sequence: latch magnitudes/signs -> sum of squares -> 16-cycle isqrt ->
// three 15-iteration restoring divisions (x, y, z) -> hold result.
// A zero-length vector skips the divisions and reports zero_vec.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   in_valid / in_ready   : input handshake, in_ready only while idle
//   dir_x, dir_y, dir_z   : signed Q8.8 light vector
//   out_valid / out_ready : output handshake, result held until accepted
//   unit_x, unit_y, unit_z: signed Q1.14 unit direction (0 for zero vector)
//   zero_vec              : input vector was (0,0,0)
//   busy                  : any state other than IDLE
//   dir_len               : unsigned Q8.8 length, only when
//                           LIGHT_NORM_LEN_OUT_EN is defined
// ---------------------------------------------------------------------------
module light_normalize
    import lambert_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dir_x,
    input  logic [15:0] dir_y,
    input  logic [15:0] dir_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] unit_x,
    output logic [15:0] unit_y,
    output logic [15:0] unit_z,
    output logic        zero_vec,
`ifdef LIGHT_NORM_LEN_OUT_EN
    output logic [15:0] dir_len,
`endif
    output logic        busy
);

    state_t      state_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        busy_reg;
    logic        zero_vec_reg;
    vec16_t      unit_reg;

    logic [15:0] mag_reg [3];
    logic [2:0]  sign_reg;

    vec16_t      dir_vec;
    logic [15:0] dir_arr [3];
    logic [15:0] mag_in  [3];
    logic [31:0] sq      [3];
    logic [31:0] sum_sq;

    logic        sqrt_start;
    logic        sqrt_done;
    logic [15:0] sqrt_root;

    logic [16:0]          div_rem_reg;
    logic [DIV_ITERS-1:0] div_quo_reg;
    logic [3:0]           div_iter_reg;
    logic [1:0]           div_comp_reg;
    logic [DIV_ITERS-1:0] res_x_reg;
    logic [DIV_ITERS-1:0] res_y_reg;

    logic                 div_ge;
    logic [16:0]          div_rem_next;
    logic [DIV_ITERS-1:0] div_quo_next;
    logic [15:0]          div_next_mag;
    logic                 div_last_iter;

`ifdef LIGHT_NORM_LEN_OUT_EN
    logic [15:0] dir_len_reg;
`endif

    assign dir_vec    = '{x: dir_x, y: dir_y, z: dir_z};
    assign dir_arr[0] = dir_vec.x;
    assign dir_arr[1] = dir_vec.y;
    assign dir_arr[2] = dir_vec.z;

    // 0x8000 negates to itself, which read as unsigned is the correct 32768.
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_comp
        assign mag_in[gi] = dir_arr[gi][15] ? -dir_arr[gi] : dir_arr[gi];
        assign sq[gi]     = {16'b0, mag_reg[gi]} * {16'b0, mag_reg[gi]};
    end

    // Upper bound is 3 * 2^30, fits in 32 bits.
    assign sum_sq     = sq[0] + sq[1] + sq[2];
    assign sqrt_start = (state_reg == SUM);

    isqrt_seq u_isqrt (
        .clk      (clk),
        .reset    (reset),
        .start    (sqrt_start),
        .radicand (sum_sq),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    // Restoring division step. The partial remainder starts at |c| rather
    // than |c|<<14: the appended dividend bits are all zero, so long division
    // only needs the remainder doubled each step. |c| <= len keeps the
    // remainder below 2*len, which fits 17 bits.
    always_comb begin
        div_ge        = (div_rem_reg >= {1'b0, sqrt_root});
        div_rem_next  = 17'((div_ge ? div_rem_reg - {1'b0, sqrt_root} : div_rem_reg) << 1);
        div_quo_next  = DIV_ITERS'({div_quo_reg, div_ge});
        div_next_mag  = (div_comp_reg == 2'd0) ? mag_reg[1] : mag_reg[2];
        div_last_iter = (div_iter_reg == 4'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            zero_vec_reg  <= 1'b0;
            unit_reg      <= '0;
            for (int i = 0; i < 3; i++) begin
                mag_reg[i] <= '0;
            end
            sign_reg      <= '0;
            div_rem_reg   <= '0;
            div_quo_reg   <= '0;
            div_iter_reg  <= '0;
            div_comp_reg  <= '0;
            res_x_reg     <= '0;
            res_y_reg     <= '0;
`ifdef LIGHT_NORM_LEN_OUT_EN
            dir_len_reg   <= '0;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            mag_reg[i]  <= mag_in[i];
                            sign_reg[i] <= dir_arr[i][15];
                        end
                        state_reg    <= SUM;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end

                SUM: begin
                    state_reg <= SQRT;
                end

                SQRT: begin
                    if (sqrt_done) begin
                        if (sqrt_root == '0) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            zero_vec_reg  <= 1'b1;
                            unit_reg      <= '0;
`ifdef LIGHT_NORM_LEN_OUT_EN
                            dir_len_reg   <= '0;
`endif
                        end else begin
                            state_reg    <= DIV;
                            div_rem_reg  <= {1'b0, mag_reg[0]};
                            div_quo_reg  <= '0;
                            div_iter_reg <= '0;
                            div_comp_reg <= '0;
                        end
                    end
                end

                DIV: begin
                    div_rem_reg  <= div_rem_next;
                    div_quo_reg  <= div_quo_next;
                    div_iter_reg <= div_iter_reg + 4'd1;
                    if (div_last_iter) begin
                        // Component finished: park its quotient and reload
                        // the shared datapath with the next magnitude.
                        div_iter_reg <= '0;
                        div_quo_reg  <= '0;
                        div_rem_reg  <= {1'b0, div_next_mag};
                        div_comp_reg <= div_comp_reg + 2'd1;
                        if (div_comp_reg == 2'd0) begin
                            res_x_reg <= div_quo_next;
                        end
                        if (div_comp_reg == 2'd1) begin
                            res_y_reg <= div_quo_next;
                        end
                        if (div_comp_reg == 2'd2) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            zero_vec_reg  <= 1'b0;
                            unit_reg.x    <= apply_sign(res_x_reg, sign_reg[0]);
                            unit_reg.y    <= apply_sign(res_y_reg, sign_reg[1]);
                            unit_reg.z    <= apply_sign(div_quo_next, sign_reg[2]);
`ifdef LIGHT_NORM_LEN_OUT_EN
                            dir_len_reg   <= sqrt_root;
`endif
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign zero_vec  = zero_vec_reg;
    assign unit_x    = unit_reg.x;
    assign unit_y    = unit_reg.y;
    assign unit_z    = unit_reg.z;
`ifdef LIGHT_NORM_LEN_OUT_EN
    assign dir_len   = dir_len_reg;
`endif

endmodule

// File: tb/tb_light_normalize.sv
`timescale 1ns/1ps
module tb_light_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dir_x, dir_y, dir_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] unit_x, unit_y, unit_z;
    logic        zero_vec;
    logic        busy;
`ifdef LIGHT_NORM_LEN_OUT_EN
    logic [15:0] dir_len;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .dir_z     (dir_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .unit_x    (unit_x),
        .unit_y    (unit_y),
        .unit_z    (unit_z),
        .zero_vec  (zero_vec),
`ifdef LIGHT_NORM_LEN_OUT_EN
        .dir_len   (dir_len),
`endif
        .busy      (busy)
    );

    // Directed vectors with hand-derived expectations.
    logic [15:0] tbl_x  [4] = '{16'h0300, 16'hFF00, 16'h8000, 16'h0000};
    logic [15:0] tbl_y  [4] = '{16'h0400, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tbl_z  [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tbl_ux [4] = '{16'd9830, 16'hC000, 16'hC000, 16'h0000};
    logic [15:0] tbl_uy [4] = '{16'd13107, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tbl_uz [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        tbl_zv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          tbl_lat[4] = '{63, 63, 63, 18};

    // Reference: real-valued vector length floored to an integer, then
    // unit = trunc(c * 2^14 / len) with the sign of c.
    function automatic void ref_model(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z,
                                      output logic [15:0] ux, output logic [15:0] uy,
                                      output logic [15:0] uz, output logic zv,
                                      output int rise_cycle);
        longint c   [3];
        longint m   [3];
        logic [15:0] u [3];
        longint sum, len, q;
        c[0] = longint'($signed(x));
        c[1] = longint'($signed(y));
        c[2] = longint'($signed(z));
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            m[i] = (c[i] < 0) ? -c[i] : c[i];
            sum += m[i] * m[i];
        end
        len = longint'($floor($sqrt(real'(sum))));
        while (len * len > sum) len--;
        while ((len + 1) * (len + 1) <= sum) len++;
        if (len == 0) begin
            for (int i = 0; i < 3; i++) u[i] = 16'h0000;
            zv = 1'b1;
            rise_cycle = 18;
        end else begin
            for (int i = 0; i < 3; i++) begin
                q = (m[i] * 16384) / len;
                u[i] = (c[i] < 0) ? 16'(-q) : 16'(q);
            end
            zv = 1'b0;
            rise_cycle = 63;
        end
        ux = u[0];
        uy = u[1];
        uz = u[2];
    endfunction

    // Presents one vector for one clock; returns whether the block was idle.
    // Ends at the falling edge of cycle 1 (the cycle after the handshake edge).
    task automatic drive_vector(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z, output bit accepted);
        @(negedge clk);
        accepted = (in_ready === 1'b1);
        dir_x = x;
        dir_y = y;
        dir_z = z;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; cyc is the cycle in which it is first seen.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (zero_vec !== 1'b0) begin failures++; $display("FAIL reset_zero_vec got=%b exp=0", zero_vec); end
        checks++; if ({unit_x, unit_y, unit_z} !== 48'h0) begin failures++; $display("FAIL reset_units got=%h exp=0", {unit_x, unit_y, unit_z}); end
        $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_directed();
        bit acc;
        int cyc;
        for (int k = 0; k < 4; k++) begin
            drive_vector(tbl_x[k], tbl_y[k], tbl_z[k], acc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL dir%0d_accept got=%b exp=1", k, acc); end
            checks++; if ({busy, in_ready} !== 2'b10) begin failures++; $display("FAIL dir%0d_busy got=%b exp=10", k, {busy, in_ready}); end
            wait_result(cyc);
            checks++; if (cyc != tbl_lat[k]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, cyc, tbl_lat[k]); end
            checks++; if (unit_x !== tbl_ux[k]) begin failures++; $display("FAIL dir%0d_unit_x got=%h exp=%h", k, unit_x, tbl_ux[k]); end
            checks++; if (unit_y !== tbl_uy[k]) begin failures++; $display("FAIL dir%0d_unit_y got=%h exp=%h", k, unit_y, tbl_uy[k]); end
            checks++; if (unit_z !== tbl_uz[k]) begin failures++; $display("FAIL dir%0d_unit_z got=%h exp=%h", k, unit_z, tbl_uz[k]); end
            checks++; if (zero_vec !== tbl_zv[k]) begin failures++; $display("FAIL dir%0d_zero_vec got=%b exp=%b", k, zero_vec, tbl_zv[k]); end
            $display("directed %0d: in=(%h,%h,%h) unit=(%h,%h,%h) zero=%b cycle=%0d",
                     k, tbl_x[k], tbl_y[k], tbl_z[k], unit_x, unit_y, unit_z, zero_vec, cyc);
            release_result();
        end
    endtask

    task automatic test_random();
        bit acc;
        int cyc, exp_cyc, mode;
        logic [15:0] v [3];
        logic [15:0] ex, ey, ez;
        logic ezv;
        for (int k = 0; k < 16; k++) begin
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 3; i++) begin
                if (mode == 0) v[i] = 16'($urandom);
                else if (mode == 1) v[i] = 16'(int'($urandom_range(0, 16)) - 8);
                else v[i] = 16'h0000;
            end
            if (mode == 2) v[$urandom_range(0, 2)] = 16'($urandom);
            ref_model(v[0], v[1], v[2], ex, ey, ez, ezv, exp_cyc);
            drive_vector(v[0], v[1], v[2], acc);
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL rnd%0d_accept got=%b exp=1", k, acc); end
            wait_result(cyc);
            checks++; if (cyc != exp_cyc) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, cyc, exp_cyc); end
            checks++; if ({unit_x, unit_y, unit_z} !== {ex, ey, ez}) begin failures++; $display("FAIL rnd%0d_units got=(%h,%h,%h) exp=(%h,%h,%h)", k, unit_x, unit_y, unit_z, ex, ey, ez); end
            checks++; if (zero_vec !== ezv) begin failures++; $display("FAIL rnd%0d_zero_vec got=%b exp=%b", k, zero_vec, ezv); end
            $display("random %0d: in=(%h,%h,%h) unit=(%h,%h,%h) zero=%b cycle=%0d",
                     k, v[0], v[1], v[2], unit_x, unit_y, unit_z, zero_vec, cyc);
            release_result();
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int cyc, exp_cyc;
        logic [15:0] ax, ay, az, bx, by, bz;
        logic [15:0] ex, ey, ez;
        logic ezv;
        logic [48:0] snap;
        ax = 16'($urandom); ay = 16'($urandom); az = 16'h0100;
        bx = 16'($urandom); by = 16'hFD80; bz = 16'($urandom);
        ref_model(ax, ay, az, ex, ey, ez, ezv, exp_cyc);
        drive_vector(ax, ay, az, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bp_accept_a got=%b exp=1", acc); end
        wait_result(cyc);
        checks++; if ({unit_x, unit_y, unit_z} !== {ex, ey, ez}) begin failures++; $display("FAIL bp_units_a got=(%h,%h,%h) exp=(%h,%h,%h)", unit_x, unit_y, unit_z, ex, ey, ez); end
        snap = {unit_x, unit_y, unit_z, zero_vec};
        dir_x = bx; dir_y = by; dir_z = bz;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready c=%0d got=%b exp=0", c, in_ready); end
            checks++; if ({unit_x, unit_y, unit_z, zero_vec} !== snap) begin failures++; $display("FAIL bp_hold_stable c=%0d got=%h exp=%h", c, {unit_x, unit_y, unit_z, zero_vec}, snap); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL bp_release_idle got=%b exp=10", {in_ready, out_valid}); end
        checks++; if ({unit_x, unit_y, unit_z, zero_vec} !== snap) begin failures++; $display("FAIL bp_idle_hold got=%h exp=%h", {unit_x, unit_y, unit_z, zero_vec}, snap); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({busy, in_ready} !== 2'b10) begin failures++; $display("FAIL bp_accept_b got=%b exp=10", {busy, in_ready}); end
        ref_model(bx, by, bz, ex, ey, ez, ezv, exp_cyc);
        wait_result(cyc);
        checks++; if (cyc != exp_cyc) begin failures++; $display("FAIL bp_latency_b got=%0d exp=%0d", cyc, exp_cyc); end
        checks++; if ({unit_x, unit_y, unit_z} !== {ex, ey, ez}) begin failures++; $display("FAIL bp_units_b got=(%h,%h,%h) exp=(%h,%h,%h)", unit_x, unit_y, unit_z, ex, ey, ez); end
        $display("backpressure: a=(%h,%h,%h) b=(%h,%h,%h) unit_b=(%h,%h,%h) cycle=%0d",
                 ax, ay, az, bx, by, bz, unit_x, unit_y, unit_z, cyc);
        release_result();
    endtask

    task automatic test_reset_abort();
        bit acc, seen;
        int cyc, exp_cyc;
        logic [15:0] ex, ey, ez;
        logic ezv;
        drive_vector(16'h0300, 16'h0400, 16'h0000, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL abort_accept got=%b exp=1", acc); end
        for (int c = 1; c < 30; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({in_ready, out_valid, busy, zero_vec} !== 4'b1000) begin failures++; $display("FAIL abort_flags got=%b exp=1000", {in_ready, out_valid, busy, zero_vec}); end
        checks++; if ({unit_x, unit_y, unit_z} !== 48'h0) begin failures++; $display("FAIL abort_units got=%h exp=0", {unit_x, unit_y, unit_z}); end
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_valid got=%b exp=0", seen); end
        ref_model(16'hFA80, 16'h0200, 16'h0740, ex, ey, ez, ezv, exp_cyc);
        drive_vector(16'hFA80, 16'h0200, 16'h0740, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL abort_fresh_accept got=%b exp=1", acc); end
        wait_result(cyc);
        checks++; if (cyc != exp_cyc) begin failures++; $display("FAIL abort_fresh_latency got=%0d exp=%0d", cyc, exp_cyc); end
        checks++; if ({unit_x, unit_y, unit_z} !== {ex, ey, ez}) begin failures++; $display("FAIL abort_fresh_units got=(%h,%h,%h) exp=(%h,%h,%h)", unit_x, unit_y, unit_z, ex, ey, ez); end
        $display("reset abort: fresh unit=(%h,%h,%h) cycle=%0d", unit_x, unit_y, unit_z, cyc);
        release_result();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dir_x     = 16'h0000;
        dir_y     = 16'h0000;
        dir_z     = 16'h0000;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog timeout");
    end

endmodule
